imem_dump: RTL and testbench

//   Read-back path for instruction memory: walks a range of imem words and emits each as a 7-byte

---
 rtl/imem_dump.sv | 132 +++++++++++++
 tb/tb_imem_dump.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dump.sv
// Instruction-memory read-back: walks a word range and emits each word as a
// 7-byte loader-compatible frame on port B, one byte per valid/ack handshake.
module imem_dump #(
  parameter int ADR_W      = 10,
  parameter int DATA_W     = 40,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W:0]    word_count,
  output logic              imem_read_en,
  output logic [ADR_W-1:0]  imem_read_adr,
  input  logic [DATA_W-1:0] imem_read_data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ack,
  output logic              port_b_oe,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = 16 + DATA_W;
  localparam int NBYTES  = FRAME_W / 8;
  localparam int IDX_W   = $clog2(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic                 go_q, go_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [ADR_W:0]       remaining_q, remaining_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [15:0]          adr_field;

  assign adr_field = 16'(adr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      adr_q       <= '0;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      byte_idx_q  <= '0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      byte_idx_q  <= byte_idx_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    go_d         = go_q;
    adr_d        = adr_q;
    remaining_d  = remaining_q;
    wait_cnt_d   = wait_cnt_q;
    byte_idx_d   = byte_idx_q;
    frame_d      = frame_q;
    imem_read_en = 1'b0;
    byte_valid   = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // go_q holds the accepted request for one cycle so busy rises before the FSM moves
        if (go_q) begin
          go_d    = 1'b0;
          state_d = (remaining_q == '0) ? S_FIN : S_READ;
        end else if (start) begin
          go_d        = 1'b1;
          adr_d       = start_adr;
          remaining_d = word_count;
        end
      end
      S_READ: begin
        imem_read_en = 1'b1;
        wait_cnt_d   = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'(RD_LATENCY - 1)) begin
          frame_d    = {adr_field, imem_read_data};
          byte_idx_d = '0;
          state_d    = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_SEND: begin
        byte_valid = 1'b1;
        if (byte_ack) begin
          // frame shifts left so the byte on the wire is always the top byte
          frame_d = frame_q << 8;
          if (byte_idx_q == IDX_W'(NBYTES - 1)) begin
            remaining_d = remaining_q - (ADR_W + 1)'(1);
            adr_d       = adr_q + ADR_W'(1);
            state_d     = (remaining_q == (ADR_W + 1)'(1)) ? S_FIN : S_READ;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE) || go_q;
  assign port_b_oe     = busy;
  assign imem_read_adr = imem_read_en ? adr_q : '0;
  assign byte_out      = byte_valid ? frame_q[FRAME_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_imem_dump.sv
// Directed bench for imem_dump: behavioural imem with 1-cycle read latency,
// a byte/read/done monitor and hand-computed expected frames.
module tb_imem_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  start_adr;
  logic [10:0] word_count;
  logic        imem_read_en;
  logic [9:0]  imem_read_adr;
  logic [39:0] imem_read_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ack;
  logic        port_b_oe;
  logic        busy;
  logic        done;

  imem_dump #(.ADR_W(10), .DATA_W(40), .RD_LATENCY(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_adr      (start_adr),
    .word_count     (word_count),
    .imem_read_en   (imem_read_en),
    .imem_read_adr  (imem_read_adr),
    .imem_read_data (imem_read_data),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .byte_ack       (byte_ack),
    .port_b_oe      (port_b_oe),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [39:0] mem [0:1023];
  always @(posedge clk) if (imem_read_en) imem_read_data <= mem[imem_read_adr];

  int          cyc = 0;
  logic [7:0]  got [$];
  int          got_cyc [$];
  int          rd [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc  = 0;
  int          vld_cnt  = 0;
  int          stab_err = 0;
  logic        prev_v = 1'b0;
  logic        prev_a = 1'b0;
  logic [7:0]  prev_b = 8'h00;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (start && !busy) acc_cyc = cyc;
      if (prev_v && !prev_a && (!byte_valid || byte_out != prev_b)) stab_err++;
      if (byte_valid) vld_cnt++;
      if (byte_valid && byte_ack) begin
        got.push_back(byte_out);
        got_cyc.push_back(cyc);
      end
      if (imem_read_en) rd.push_back(int'(imem_read_adr));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_v = byte_valid;
      prev_a = byte_ack;
      prev_b = byte_out;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input logic [9:0] a, input logic [10:0] c);
    @(posedge clk); #1;
    start = 1'b1; start_adr = a; word_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string tag);
    int k = 0;
    while (done_cnt == base && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, 64'(done_cnt - base), 64'd1);
  endtask

  function automatic logic [7:0] gb_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 8'hxx;
  endfunction

  function automatic int rd_at(input int idx);
    if (idx < rd.size()) return rd[idx];
    return -1;
  endfunction

  logic [7:0] e1 [7] = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
  logic [7:0] e3 [7] = '{8'h00, 8'h64, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gb, rb, db, vb, sb, k;
    for (int i = 0; i < 1024; i++) mem[i] = 40'(i) * 40'h0101;
    mem[5]    = 40'h12_3456_789A;
    mem[1022] = 40'hAA_BBCC_DDEE;
    mem[1023] = 40'h99_8877_6655;
    mem[0]    = 40'h01_0203_0405;
    mem[100]  = 40'h11_2233_4455;
    mem[51]   = 40'hF1_F2F3_F4F5;

    reset = 1'b1; start = 1'b0; start_adr = '0; word_count = '0; byte_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst oe", 64'(port_b_oe), 64'd0);
    check("rst valid", 64'(byte_valid), 64'd0);
    check("rst byte", 64'(byte_out), 64'd0);
    check("rst rden", 64'(imem_read_en), 64'd0);
    check("rst done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // single word, ack tied high
    gb = got.size(); rb = rd.size(); db = done_cnt;
    byte_ack = 1'b1;
    do_start(10'd5, 11'd1);
    wait_done(db, 100, "t1");
    check("t1 nbytes", 64'(got.size() - gb), 64'd7);
    for (int i = 0; i < 7; i++) check($sformatf("t1 byte%0d", i), 64'(gb_at(gb + i)), 64'(e1[i]));
    check("t1 first lat", 64'(got_cyc[gb] - acc_cyc), 64'd4);
    check("t1 consecutive", 64'(got_cyc[gb + 6] - got_cyc[gb]), 64'd6);
    check("t1 done cyc", 64'(done_cyc - got_cyc[gb + 6]), 64'd1);
    check("t1 nreads", 64'(rd.size() - rb), 64'd1);
    check("t1 read adr", 64'(rd_at(rb)), 64'd5);
    @(negedge clk);
    check("t1 busy after", 64'(busy), 64'd0);

    // address wrap 1022 -> 1023 -> 0
    gb = got.size(); rb = rd.size(); db = done_cnt;
    do_start(10'd1022, 11'd3);
    wait_done(db, 200, "t2");
    check("t2 nbytes", 64'(got.size() - gb), 64'd21);
    check("t2 w0 b0", 64'(gb_at(gb + 0)), 64'h03);
    check("t2 w0 b1", 64'(gb_at(gb + 1)), 64'hFE);
    check("t2 w0 b2", 64'(gb_at(gb + 2)), 64'hAA);
    check("t2 w1 b0", 64'(gb_at(gb + 7)), 64'h03);
    check("t2 w1 b1", 64'(gb_at(gb + 8)), 64'hFF);
    check("t2 w1 b6", 64'(gb_at(gb + 13)), 64'h55);
    check("t2 w2 b0", 64'(gb_at(gb + 14)), 64'h00);
    check("t2 w2 b1", 64'(gb_at(gb + 15)), 64'h00);
    check("t2 w2 b6", 64'(gb_at(gb + 20)), 64'h05);
    check("t2 rd0", 64'(rd_at(rb)), 64'd1022);
    check("t2 rd1", 64'(rd_at(rb + 1)), 64'd1023);
    check("t2 rd2", 64'(rd_at(rb + 2)), 64'd0);

    // ack stall mid-frame
    gb = got.size(); db = done_cnt; sb = stab_err;
    do_start(10'd100, 11'd1);
    k = 0;
    while (got.size() - gb < 3 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1 byte_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("t3 stall valid", 64'(byte_valid), 64'd1);
    check("t3 stall byte", 64'(byte_out), 64'h22);
    @(posedge clk); #1 byte_ack = 1'b1;
    wait_done(db, 100, "t3");
    check("t3 nbytes", 64'(got.size() - gb), 64'd7);
    for (int i = 0; i < 7; i++) check($sformatf("t3 byte%0d", i), 64'(gb_at(gb + i)), 64'(e3[i]));
    check("t3 stable", 64'(stab_err - sb), 64'd0);

    // zero count, plus a start coinciding with the done cycle
    rb = rd.size(); db = done_cnt; vb = vld_cnt;
    do_start(10'd33, 11'd0);
    @(posedge clk); #1;
    start = 1'b1; start_adr = 10'd400; word_count = 11'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("t4 done cnt", 64'(done_cnt - db), 64'd1);
    check("t4 done lat", 64'(done_cyc - acc_cyc), 64'd2);
    check("t4 no read", 64'(rd.size() - rb), 64'd0);
    check("t4 no valid", 64'(vld_cnt - vb), 64'd0);
    check("t4 idle", 64'(busy), 64'd0);

    // start while busy is ignored
    gb = got.size(); rb = rd.size(); db = done_cnt;
    do_start(10'd200, 11'd2);
    @(posedge clk); #1;
    start = 1'b1; start_adr = 10'd300; word_count = 11'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(db, 200, "t5");
    repeat (10) @(negedge clk);
    check("t5 done cnt", 64'(done_cnt - db), 64'd1);
    check("t5 nreads", 64'(rd.size() - rb), 64'd2);
    check("t5 rd0", 64'(rd_at(rb)), 64'd200);
    check("t5 rd1", 64'(rd_at(rb + 1)), 64'd201);
    check("t5 nbytes", 64'(got.size() - gb), 64'd14);
    check("t5 w0 adr", 64'(gb_at(gb + 1)), 64'hC8);
    check("t5 w1 adr", 64'(gb_at(gb + 8)), 64'hC9);

    // reset during byte 3 of word 2, then a clean dump
    gb = got.size(); db = done_cnt;
    do_start(10'd50, 11'd3);
    k = 0;
    while (got.size() - gb < 10 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1 byte_ack = 1'b0;
    @(posedge clk); #2;
    check("t6 pre valid", 64'(byte_valid), 64'd1);
    check("t6 pre byte", 64'(byte_out), 64'hF2);
    #1 reset = 1'b1;
    #1;
    check("t6 valid", 64'(byte_valid), 64'd0);
    check("t6 oe", 64'(port_b_oe), 64'd0);
    check("t6 busy", 64'(busy), 64'd0);
    check("t6 byte", 64'(byte_out), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6 no done", 64'(done_cnt - db), 64'd0);
    gb = got.size(); rb = rd.size(); db = done_cnt;
    byte_ack = 1'b1;
    do_start(10'd7, 11'd1);
    wait_done(db, 100, "t6b");
    check("t6b nbytes", 64'(got.size() - gb), 64'd7);
    check("t6b adr lo", 64'(gb_at(gb + 1)), 64'h07);
    check("t6b rd", 64'(rd_at(rb)), 64'd7);

    // full memory from 1000, wrapping
    gb = got.size(); rb = rd.size(); db = done_cnt;
    do_start(10'd1000, 11'd1024);
    wait_done(db, 12000, "t7");
    check("t7 nreads", 64'(rd.size() - rb), 64'd1024);
    check("t7 first", 64'(rd_at(rb)), 64'd1000);
    check("t7 last", 64'(rd_at(rb + 1023)), 64'd999);
    check("t7 nbytes", 64'(got.size() - gb), 64'd7168);
    check("t7 stable", 64'(stab_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
